// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring phase monitor.
// Helpers work on MAX_W-wide vectors with an explicit ring width so that
// any instance width up to MAX_W can reuse them.
package ring_mon_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    UNSYNC,
    LOCKED,
    ERR
  } mon_state_t;

  // INIT pattern (MSB-only) for a ring of width w
  function automatic logic [MAX_W-1:0] init_pat(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

  // Expected successor: rotate right by one within a ring of width w
  function automatic logic [MAX_W-1:0] rot(input logic [MAX_W-1:0] p,
                                           input int unsigned     w);
    logic [MAX_W-1:0] pm;
    pm = p & ((init_pat(w) << 1) - MAX_W'(1));
    return (pm >> 1) | (MAX_W'(pm[0]) << (w - 1));
  endfunction

  // Exactly one bit set
  function automatic logic is_onehot(input logic [MAX_W-1:0] p);
    return (p != '0) && ((p & (p - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ring_phase_monitor_onehot_enc.sv
// One-hot to phase-index encoder: MSB maps to index 0, LSB to WIDTH-1.
// legal is high only when exactly one bit is set.
module onehot_enc
  import ring_mon_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             legal
);

  // Priority scan; for illegal inputs idx is don't-care but defined
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IW'(WIDTH - 1 - i);
    end
    legal = is_onehot(MAX_W'(vec));
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Ring phase monitor: checks a one-hot ring counter for legal rotation,
// reports its phase and counts revolutions.
// Optional macro RING_MON_RELOCK_EN: allow ERR to re-lock on a legal
// rotation step without a ring_clr (sticky error is kept).
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned REV_W = 8,
  localparam int unsigned PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ring_clr,
  input  logic [WIDTH-1:0] ring_q,
  output logic [PW-1:0]    phase,
  output logic             locked,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_cnt,
  output logic             err,
  output logic             err_stky
);

  localparam logic [WIDTH-1:0] INIT    = WIDTH'(init_pat(WIDTH));
  localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

  mon_state_t       state_q, state_d;
  logic [WIDTH-1:0] cur, prev_q, exp_q;
  logic             clr_d;
  logic [PW-1:0]    cur_idx;
  logic             cur_legal;
  logic             relock_clr, err_d, tick_d;

  assign cur   = ring_q;
  assign exp_q = WIDTH'(rot(MAX_W'(prev_q), WIDTH));

`ifdef RING_MON_RELOCK_EN
  logic prev_legal;
  assign prev_legal = is_onehot(MAX_W'(prev_q));
`endif

  onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .vec   (cur),
    .idx   (cur_idx),
    .legal (cur_legal)
  );

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= UNSYNC;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    relock_clr = 1'b0;
    case (state_q)
      UNSYNC: if (clr_d && cur == INIT) state_d = LOCKED;
      LOCKED: begin
        if (clr_d) begin
          if (cur != INIT) state_d = ERR;
        end else if (!(cur_legal && cur == exp_q)) begin
          state_d = ERR;
        end
      end
      ERR: begin
        if (clr_d && cur == INIT) begin
          state_d    = LOCKED;
          relock_clr = 1'b1;
        end
`ifdef RING_MON_RELOCK_EN
        else if (prev_legal && cur == exp_q) begin
          state_d = LOCKED;
        end
`endif
      end
      default: state_d = UNSYNC;
    endcase
  end

  assign err_d  = (state_q == LOCKED) && (state_d == ERR);
  // A reload (clr_d) never counts as a revolution
  assign tick_d = (state_q == LOCKED) && !clr_d && (prev_q == LSB_ONE) && (cur == INIT);
  assign locked = (state_q == LOCKED);

  // Sample history and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev_q   <= '0;
      clr_d    <= 1'b0;
      phase    <= '0;
      rev_tick <= 1'b0;
      rev_cnt  <= '0;
      err      <= 1'b0;
      err_stky <= 1'b0;
    end else begin
      prev_q   <= cur;
      clr_d    <= ring_clr;
      rev_tick <= tick_d;
      err      <= err_d;
      if (state_d == LOCKED) phase <= cur_idx;
      if (clr_d)       rev_cnt <= '0;
      else if (tick_d) rev_cnt <= rev_cnt + REV_W'(1);
      if (err_d)           err_stky <= 1'b1;
      else if (relock_clr) err_stky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: directed scenarios plus a randomized ring
// with glitches, clears and resets, checked against a behavioural model.
module tb_ring_phase_monitor;

  logic       clk = 1'b0;
  logic       clr_n, ring_clr;
  logic [3:0] ring_q;

  logic [1:0] phase_a, phase_b;
  logic       locked_a, locked_b, tick_a, tick_b, err_a, err_b, stky_a, stky_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  ring_phase_monitor #(.WIDTH(4), .REV_W(8)) dut_a (
    .clk(clk), .clr_n(clr_n), .ring_clr(ring_clr), .ring_q(ring_q),
    .phase(phase_a), .locked(locked_a), .rev_tick(tick_a), .rev_cnt(cnt_a),
    .err(err_a), .err_stky(stky_a)
  );

  ring_phase_monitor #(.WIDTH(4), .REV_W(2)) dut_b (
    .clk(clk), .clr_n(clr_n), .ring_clr(ring_clr), .ring_q(ring_q),
    .phase(phase_b), .locked(locked_b), .rev_tick(tick_b), .rev_cnt(cnt_b),
    .err(err_b), .err_stky(stky_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: m_st 0 = unsynchronised, 1 = locked, 2 = error
  int m_st, m_prev, m_clrd, m_phase, m_locked, m_tick, m_cnt, m_err, m_stky;
  int rq;  // the upstream ring counter's true contents

  function automatic int rot4(input int p);
    return ((p >> 1) | ((p & 1) << 3)) & 15;
  endfunction

  function automatic int msb_pos(input int p);
    int r = 0;
    for (int k = 0; k < 4; k++) if (p == (8 >> k)) r = k;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_prev = 0; m_clrd = 0; m_phase = 0; m_locked = 0;
    m_tick = 0; m_cnt = 0; m_err = 0; m_stky = 0;
  endtask

  task automatic model_edge();
    int cur, nxt;
    bit ok;
    if (!clr_n) begin
      model_reset();
      return;
    end
    cur = int'(ring_q);
    nxt = m_st;
    m_tick = 0;
    m_err  = 0;
    if (m_st == 0) begin
      if (m_clrd == 1 && cur == 8) nxt = 1;
    end else if (m_st == 1) begin
      ok = (m_clrd == 1) ? (cur == 8) : (cur == rot4(m_prev));
      if (!ok) nxt = 2;
      m_tick = (m_clrd == 0 && m_prev == 1 && cur == 8) ? 1 : 0;
    end else begin
      if (m_clrd == 1 && cur == 8) begin
        nxt = 1;
        m_stky = 0;
      end
`ifdef RING_MON_RELOCK_EN
      else if ($countones(m_prev) == 1 && cur == rot4(m_prev)) nxt = 1;
`endif
    end
    if (m_st == 1 && nxt == 2) begin
      m_err  = 1;
      m_stky = 1;
    end
    if (m_clrd == 1) m_cnt = 0;
    else if (m_tick == 1) m_cnt++;
    if (nxt == 1) m_phase = msb_pos(cur);
    m_locked = (nxt == 1) ? 1 : 0;
    m_st   = nxt;
    m_prev = cur;
    m_clrd = int'(ring_clr);
  endtask

  task automatic check_all();
    chk("phase_a",  32'(phase_a),  m_phase);
    chk("locked_a", 32'(locked_a), m_locked);
    chk("tick_a",   32'(tick_a),   m_tick);
    chk("cnt_a",    32'(cnt_a),    m_cnt % 256);
    chk("err_a",    32'(err_a),    m_err);
    chk("stky_a",   32'(stky_a),   m_stky);
    chk("phase_b",  32'(phase_b),  m_phase);
    chk("locked_b", 32'(locked_b), m_locked);
    chk("tick_b",   32'(tick_b),   m_tick);
    chk("cnt_b",    32'(cnt_b),    m_cnt % 4);
    chk("err_b",    32'(err_b),    m_err);
    chk("stky_b",   32'(stky_b),   m_stky);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Drive the ring's true value; a clear reloads INIT for the next cycle
  task automatic ring_cycle(input bit clr);
    ring_clr = clr;
    ring_q   = 4'(rq);
    tick();
    rq = clr ? 8 : rot4(rq);
  endtask

  // Drive a corrupted value while the real ring keeps running
  task automatic ring_cycle_q(input bit clr, input int q);
    ring_clr = clr;
    ring_q   = 4'(q);
    tick();
    rq = clr ? 8 : rot4(rq);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_phase"},  32'(phase_a),  0);
    chk({tag, "_locked"}, 32'(locked_a), 0);
    chk({tag, "_tick"},   32'(tick_a),   0);
    chk({tag, "_cnt"},    32'(cnt_a),    0);
    chk({tag, "_err"},    32'(err_a),    0);
    chk({tag, "_stky"},   32'(stky_a),   0);
  endtask

  // Reset between edges, checked before any clock edge arrives
  task automatic async_reset_pulse(input string tag);
    #3;
    clr_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    ring_cycle(0);
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0; ring_clr = 1'b0; ring_q = '0; rq = 2;
    model_reset();
    #1;
    check_zero("rst");
    repeat (2) tick();
    clr_n = 1'b1;

    // Lock, then free-run
    ring_cycle(1);
    repeat (9) ring_cycle(0);
    chk("t1_cnt", 32'(cnt_a), 2);
    chk("t1_locked", 32'(locked_a), 1);

    // Four revolutions: narrow counter wraps
    repeat (8) ring_cycle(0);
    chk("t4_cnt_a", 32'(cnt_a), 4);
    chk("t4_cnt_b", 32'(cnt_b), 0);

    // Clear mid-revolution, then hold it
    repeat (2) ring_cycle(0);
    ring_cycle(1);
    ring_cycle(0);
    chk("t4_clr_cnt", 32'(cnt_a), 0);
    chk("t4_clr_phase", 32'(phase_a), 0);
    chk("t4_clr_tick", 32'(tick_a), 0);
    repeat (3) ring_cycle(1);
    chk("hold_locked", 32'(locked_a), 1);
    chk("hold_phase", 32'(phase_a), 0);

    // Multi-hot while locked
    repeat (2) ring_cycle(0);
    ring_cycle_q(0, 6);
    chk("t2_err", 32'(err_a), 1);
    chk("t2_stky", 32'(stky_a), 1);
    chk("t2_locked", 32'(locked_a), 0);
    ring_cycle(0);
    chk("t2_err_pulse", 32'(err_a), 0);
    repeat (4) ring_cycle(0);
`ifndef RING_MON_RELOCK_EN
    chk("t2_stay_err", 32'(locked_a), 0);
`endif
    ring_cycle(1);
    ring_cycle(0);
    chk("t2_relock", 32'(locked_a), 1);

    // Skipped phase
    for (int k = 0; k < 4 && rq != 8; k++) ring_cycle(0);
    ring_cycle(0);
    rq = 2;
    ring_cycle(0);
    chk("t3_err", 32'(err_a), 1);
    ring_cycle(0);
`ifdef RING_MON_RELOCK_EN
    chk("t3_autorelock", 32'(locked_a), 1);
    chk("t3_stky_kept", 32'(stky_a), 1);
`else
    chk("t3_no_relock", 32'(locked_a), 0);
`endif
    ring_cycle(1);
    ring_cycle(0);

    // Async reset at phase 2
    for (int k = 0; k < 8 && !(m_locked == 1 && m_phase == 2); k++) ring_cycle(0);
    chk("t5_pre_phase", 32'(phase_a), 2);
    async_reset_pulse("t5");
    repeat (6) ring_cycle(0);
    chk("t5_unsync", 32'(locked_a), 0);

    // Zero / all-ones while unsynchronised
    ring_cycle_q(0, 0);
    ring_cycle_q(0, 15);
    chk("t6_err", 32'(err_a), 0);
    ring_cycle_q(1, 15);
    ring_cycle_q(0, 15);
    chk("t6_locked", 32'(locked_a), 0);
    ring_cycle(1);
    ring_cycle(0);
    chk("t6_lock", 32'(locked_a), 1);

    // Randomized ring with glitches, clears and resets
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4)       ring_cycle(1);
      else if (r < 9)  ring_cycle_q(0, int'($urandom_range(0, 15)));
      else if (r < 11) ring_cycle_q(1, int'($urandom_range(0, 15)));
      else if (r == 11) async_reset_pulse("rnd_rst");
      else             ring_cycle(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
